lsu_bus_bridge: RTL and testbench
=================================

# lsu_bus_bridge

Load/store unit sitting directly downstream of the core datapath's memory outputs (write address, write data) and upstream of its read-data input. It converts single-cycle core memory requests into a req/ack bus transaction with byte enables, lane steering and load sign/zero extension. It stalls the core until the transaction completes or times out. Makes the single-cycle core usable with multi-cycle memories.

## Interface
Parameters:
- `TIMEOUT`, default 15: number of REQ cycles without `bus_ack` before the access is aborted with an error (1..255).

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `MemRead` input 1: core requests a load this instruction.
- `MemWrite` input 1: core requests a store this instruction.
- `Funct3` input 3: access size/sign, RISC-V encoding.
- `Addr` input 32: byte address (core ALU result).
- `WrData` input 32: store data, right-aligned.
- `RdData` output 32: extended load data to the core.
- `Stall` output 1: core must hold PC and suppress register write.
- `Err` output 1: one-cycle pulse for an aborted or misaligned access.
- `bus_req` output 1: bus request, held until ack.
- `bus_we` output 1: 1 = write.
- `bus_addr` output 32: word address, `{Addr[31:2],2'b00}`.
- `bus_wdata` output 32: lane-steered store data.
- `bus_be` output 4: byte enables.
- `bus_rdata` input 32: read word.
- `bus_ack` input 1: transaction complete; `bus_rdata` is valid in the same cycle.

## Operation
- FSM states are IDLE, REQ and DONE. Reset puts the FSM in IDLE.
- `Stall = (IDLE & (MemRead|MemWrite)) | REQ`. This is combinational.
- IDLE -> REQ when `MemRead|MemWrite`. `bus_addr/we/be/wdata` are registered on that edge and held constant through REQ.
- If `MemRead` and `MemWrite` are both set, the access is a write and `RdData` is 0.
- REQ:
  - `bus_req=1`.
  - On `bus_ack`, `bus_rdata` is extended into the `RdData` register and the FSM goes to DONE.
  - If the timeout counter reaches `TIMEOUT` without ack, `RdData` is set to 0, `Err` is set and the FSM goes to DONE.
- DONE: `Stall=0` and the core retires on this edge. The FSM goes to IDLE and `Err` clears.
- `bus_ack` is ignored in IDLE and DONE.
- Size coding:
  - Byte: 000 (LB/SB) and 100 (LBU).
  - Half: 001 (LH/SH) and 101 (LHU).
  - Word: 010.
  - Other codes (011/110/111) are treated as word.
- Stores:
  - Byte: `be=4'b0001<<Addr[1:0]`, with `WrData[7:0]` replicated into all 4 lanes.
  - Half: `be=4'b0011<<{Addr[1],1'b0}`, with `WrData[15:0]` replicated into both halves.
  - Word: `be=4'hF`.
- Reads: `bus_be` is computed the same way as for stores. The lane is selected by `Addr[1:0]`. Codes 000/001 sign-extend; codes 100/101 zero-extend.

## Timing
- Reset values: `RdData=0`, `Err=0`, `bus_req=0`, `bus_we=0`, `bus_addr=0`, `bus_wdata=0`, `bus_be=0`. The state is IDLE and the timeout counter is 0.
- Minimum latency is 3 cycles (IDLE, REQ with ack, DONE): the core stalls 2 cycles.
- With ack in the k-th REQ cycle, the core stalls k+1 cycles.
- The timeout counter resets on entering REQ and increments each REQ cycle. The abort happens in REQ cycle `TIMEOUT` if no ack has arrived, so the core stalls `TIMEOUT+1` cycles.
- An ack arriving in the same cycle the counter expires takes priority, and there is no `Err`.
- `RdData` holds its value until the next DONE.
- Reset asserted mid-transaction immediately drops `bus_req` and `Stall` (asynchronously) and returns the FSM to IDLE. No ack is awaited.

## Configuration
- `LSU_MISALIGN_TRAP_EN`.
- Defined:
  - A half access with `Addr[0]=1`, or a word access with `Addr[1:0]!=0`, goes IDLE -> DONE directly.
  - No `bus_req` is issued, `Err` pulses in DONE, and `RdData=0`.
  - Stall lasts 1 cycle.
- Undefined:
  - No misalignment check is made.
  - Half accesses ignore `Addr[0]`; word accesses ignore `Addr[1:0]`.
  - The access proceeds on the bus normally.

## Test plan
- LW from `Addr=0x100` with `bus_ack` in the first REQ cycle and `bus_rdata=0xDEADBEEF`: `bus_be=F`, `bus_addr=0x100`, `Stall` high for 2 cycles, `RdData=0xDEADBEEF` in DONE.
- LB from `Addr=0x103`, `bus_rdata=0x80112233`: `bus_be=1000`, `RdData=0xFFFFFF80`. The same access as LBU gives `RdData=0x00000080`.
- SH to `Addr=0x202` with `WrData=0x0000ABCD`: `bus_we=1`, `bus_be=1100`, `bus_wdata=0xABCDABCD`, `bus_addr=0x200`. Ack is delayed 4 cycles, so `Stall` is high 5 cycles and the bus outputs are stable throughout.
- `TIMEOUT=15` with no ack on an LW: `Err` is high exactly 1 cycle, in DONE, after 15 REQ cycles, `RdData=0`, and `bus_req` then drops.
- SW to `Addr=0x301`:
  - With `LSU_MISALIGN_TRAP_EN`: no `bus_req`, `Err` pulse, 1-cycle stall.
  - Without it: a bus write to 0x300 with `be=F`.
- Assert `reset` during REQ cycle 2: `bus_req`, `Stall` and `Err` go to 0 before the next edge. A new LW issued after reset completes normally.

Source files
------------

// File: rtl/lsu_bus_bridge.sv
// lsu_bus_bridge: single-cycle core memory port to req/ack bus bridge with byte lanes and load extension
// Optional misaligned-access trap enabled by defining LSU_MISALIGN_TRAP_EN.
module lsu_bus_bridge #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  Funct3,
  input  logic [31:0] Addr,
  input  logic [31:0] WrData,
  output logic [31:0] RdData,
  output logic        Stall,
  output logic        Err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);
  state_t state, state_nx;
  logic [7:0] cnt;
  logic [1:0] sz_q, lane_q, lane;
  logic sgn_q, req, half, word, mis, expired;
  logic [3:0] be;
  logic [31:0] wdata, ext;
  logic [15:0] sh;
`ifdef LSU_MISALIGN_TRAP_EN
  assign mis = (half & Addr[0]) | (word & |Addr[1:0]);
`else
  assign mis = 1'b0;
`endif
  // Request decode, lane steering and load extension from the latched access shape
  always_comb begin
    req = MemRead | MemWrite;
    half = Funct3[1:0] == 2'b01;
    word = Funct3[1];
    lane = word ? 2'b00 : half ? {Addr[1], 1'b0} : Addr[1:0];
    be = word ? 4'hF : (half ? 4'b0011 : 4'b0001) << lane;
    wdata = word ? WrData : half ? {2{WrData[15:0]}} : {4{WrData[7:0]}};
    expired = cnt == LAST;
    sh = 16'(bus_rdata >> {lane_q, 3'b000});
    ext = sz_q[1] ? bus_rdata : sz_q[0] ? {{16{sgn_q & sh[15]}}, sh} : {{24{sgn_q & sh[7]}}, sh[7:0]};
  end
  // State register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  // Next state: ack beats timeout in the same REQ cycle
  always_comb
    state_nx = state == IDLE ? (req ? (mis ? DONE : REQ) : IDLE)
             : state == REQ ? ((bus_ack | expired) ? DONE : REQ)
             : IDLE;
  // Core stall and bus request; reset drops stall without waiting for the state to settle
  always_comb begin
    Stall = ~reset & ((state == IDLE & req) | state == REQ);
    bus_req = state == REQ;
  end
  // Bus command capture, timeout counting, load result and error pulse
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      RdData <= '0;
      Err <= 1'b0;
      bus_we <= 1'b0;
      bus_addr <= '0;
      bus_wdata <= '0;
      bus_be <= '0;
      cnt <= '0;
      sz_q <= '0;
      lane_q <= '0;
      sgn_q <= 1'b0;
    end else begin
      if (state == IDLE && req && !mis) begin
        bus_we <= MemWrite;
        bus_addr <= {Addr[31:2], 2'b00};
        bus_be <= be;
        bus_wdata <= wdata;
        sz_q <= {word, half};
        lane_q <= lane;
        sgn_q <= ~Funct3[2];
        cnt <= '0;
      end
      if (state == IDLE && req && mis) begin
        Err <= 1'b1;
        RdData <= '0;
      end
      if (state == REQ) begin
        cnt <= cnt + 8'd1;
        if (bus_ack) RdData <= bus_we ? 32'd0 : ext;
        else if (expired) begin
          RdData <= '0;
          Err <= 1'b1;
        end
      end
      if (state == DONE) Err <= 1'b0;
    end
endmodule

// File: tb/tb_lsu_bus_bridge.sv
// tb_lsu_bus_bridge: directed and randomized accesses checked against a behavioural model
module tb_lsu_bus_bridge;
  localparam int TO = 15;
`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, MemRead = 1'b0, MemWrite = 1'b0, bus_ack = 1'b0;
  logic [2:0] Funct3 = '0;
  logic [31:0] Addr = '0, WrData = '0, bus_rdata = '0;
  logic [31:0] RdData, bus_addr, bus_wdata;
  logic Stall, Err, bus_req, bus_we;
  logic [3:0] bus_be;
  int n_cmp = 0, n_bad = 0;

  lsu_bus_bridge #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite), .Funct3(Funct3),
    .Addr(Addr), .WrData(WrData), .RdData(RdData), .Stall(Stall), .Err(Err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_be(bus_be), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One core access; ack_at = REQ cycle in which ack is given (0 or >TO means never)
  task automatic access(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rdata, input int ack_at, input string nm);
    int sz, estall, stall, reqc;
    logic [3:0] ebe;
    logic [31:0] ewd, erd, rsrc;
    logic [7:0] b;
    logic [15:0] h;
    bit emis, eerr;
    sz = (f3 == 3'd0 || f3 == 3'd4) ? 0 : (f3 == 3'd1 || f3 == 3'd5) ? 1 : 2;
    ebe = sz == 0 ? 4'(1 << (a % 4)) : sz == 1 ? 4'(3 << (2 * ((a / 2) % 2))) : 4'hF;
    ewd = sz == 0 ? {4{wd[7:0]}} : sz == 1 ? {2{wd[15:0]}} : wd;
    emis = TRAP && ((sz == 1 && a[0]) || (sz == 2 && a[1:0] != 2'b00));
    rsrc = rdata;
    b = rsrc[8 * (a % 4) +: 8];
    h = rsrc[16 * ((a / 2) % 2) +: 16];
    erd = sz == 2 ? rsrc : sz == 1 ? (f3[2] ? {16'h0, h} : {{16{h[15]}}, h})
        : (f3[2] ? {24'h0, b} : {{24{b[7]}}, b});
    eerr = emis || ack_at < 1 || ack_at > TO;
    if (eerr || wr) erd = '0;
    estall = emis ? 1 : eerr ? TO + 1 : ack_at + 1;
    MemRead = rd; MemWrite = wr; Funct3 = f3; Addr = a; WrData = wd;
    stall = 0; reqc = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (!Stall) break;
      stall++;
      chk({nm, ".err_busy"}, 32'(Err), 32'd0);
      if (bus_req) begin
        reqc++;
        chk({nm, ".addr"}, bus_addr, {a[31:2], 2'b00});
        chk({nm, ".we"}, 32'(bus_we), 32'(wr));
        chk({nm, ".be"}, 32'(bus_be), 32'(ebe));
        if (wr) chk({nm, ".wdata"}, bus_wdata, ewd);
      end
      bus_ack = bus_req ? (reqc == ack_at) : 1'($urandom_range(0, 1));
      bus_rdata = (bus_req && reqc == ack_at) ? rdata : $urandom;
    end
    chk({nm, ".stall_cycles"}, 32'(stall), 32'(estall));
    chk({nm, ".req_cycles"}, 32'(reqc), 32'(emis ? 0 : estall - 1));
    chk({nm, ".err_done"}, 32'(Err), 32'(eerr));
    chk({nm, ".req_done"}, 32'(bus_req), 32'd0);
    if (rd || eerr) chk({nm, ".rddata"}, RdData, erd);
    bus_ack = 1'($urandom_range(0, 1));
    bus_rdata = $urandom;
    @(posedge clk);
    #1;
    MemRead = 1'b0; MemWrite = 1'b0;
    @(negedge clk);
    chk({nm, ".idle_stall"}, 32'(Stall), 32'd0);
    chk({nm, ".idle_err"}, 32'(Err), 32'd0);
    chk({nm, ".idle_req"}, 32'(bus_req), 32'd0);
    if (rd || eerr) chk({nm, ".rd_hold"}, RdData, erd);
    bus_ack = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    @(negedge clk);
    chk("rst.rddata", RdData, 32'd0);
    chk("rst.err", 32'(Err), 32'd0);
    chk("rst.req", 32'(bus_req), 32'd0);
    chk("rst.we", 32'(bus_we), 32'd0);
    chk("rst.addr", bus_addr, 32'd0);
    chk("rst.wdata", bus_wdata, 32'd0);
    chk("rst.be", 32'(bus_be), 32'd0);
    chk("rst.stall", 32'(Stall), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    access(1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1, "lw");
    access(1, 0, 3'b000, 32'h103, 32'h0, 32'h80112233, 2, "lb");
    access(1, 0, 3'b100, 32'h103, 32'h0, 32'h80112233, 1, "lbu");
    access(0, 1, 3'b001, 32'h202, 32'h0000ABCD, 32'h0, 4, "sh");
    access(1, 0, 3'b010, 32'h104, 32'h0, 32'h12345678, 0, "lw_timeout");
    access(1, 0, 3'b010, 32'h108, 32'h0, 32'hCAFEF00D, TO, "lw_ack_at_limit");
    access(0, 1, 3'b010, 32'h301, 32'h11223344, 32'h0, 1, "sw_misalign");
    access(1, 1, 3'b010, 32'h10, 32'h55667788, 32'hFFFFFFFF, 1, "rd_wr_both");
    access(1, 0, 3'b001, 32'h102, 32'h0, 32'h9ABC1234, 3, "lh_hi");
    access(1, 0, 3'b101, 32'h102, 32'h0, 32'h9ABC1234, 1, "lhu_hi");
    access(0, 1, 3'b000, 32'h401, 32'h000000A5, 32'h0, 2, "sb");
    // reset in the second REQ cycle, core still requesting
    MemRead = 1'b1; MemWrite = 1'b0; Funct3 = 3'b010; Addr = 32'h40;
    bus_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid.req_before", 32'(bus_req), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("mid.req", 32'(bus_req), 32'd0);
    chk("mid.stall", 32'(Stall), 32'd0);
    chk("mid.err", 32'(Err), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0; MemRead = 1'b0;
    access(1, 0, 3'b010, 32'h44, 32'h0, 32'h0BADF00D, 2, "lw_after_rst");
    for (int i = 0; i < 40; i++) begin
      int r, k;
      r = $urandom_range(1, 3);
      k = $urandom_range(0, TO + 2);
      access(r[0], r[1], 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom, k, "rnd");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
